// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os_pkg: shared state encoding, oversampling constants and clog2 helper
package uart_rx_os_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_os_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver, LSB first, configurable data
// width and stop length; emits a one-cycle done tick with the received word.
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic [DBIT-1:0] dout
);

    localparam int SW = clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
    localparam int NW = clog2(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_e          state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic            rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_q <= START;
                    s_q     <= '0;
                end
                // a start bit still low at mid-bit is genuine; otherwise it was a glitch
                START: if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            s_q     <= '0;
                            n_q     <= '0;
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                DATA: if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_q <= '0;
                        b_q <= {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) state_q <= STOP;
                        else n_q <= n_q + 1'b1;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                STOP: if (s_tick) begin
                    if (s_q == S_STOP) state_q <= IDLE;
                    else s_q <= s_q + 1'b1;
                end
            endcase
        end
    end

    assign rx_done_tick = (state_q == STOP) && s_tick && (s_q == S_STOP);
    assign frame_err    = rx_done_tick && !rx_s;
    assign dout         = b_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: table-driven and randomized frames against a frame-level
// model of two receivers (one and two stop bits).
`timescale 1ns/1ps
module tb_uart_rx_os;

    typedef struct {
        logic [7:0] d;
        bit         err;
        int         t0;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         stop;
        int         gap;
        logic [7:0] exp_d;
        bit         exp_err;
    } vec_t;

    logic       clk = 0;
    logic       reset = 1;
    logic       s_tick = 1;
    logic       rx16 = 1, rx32 = 1;
    logic       done16, ferr16, done32, ferr32;
    logic [7:0] dout16, dout32;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q16[$];
    exp_t q32[$];
    exp_t e16, e32;
    vec_t tbl[6];

    uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx16),
        .s_tick       (s_tick),
        .rx_done_tick (done16),
        .frame_err    (ferr16),
        .dout         (dout16)
    );

    uart_rx_os #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx32),
        .s_tick       (s_tick),
        .rx_done_tick (done32),
        .frame_err    (ferr32),
        .dout         (dout32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // Pulse arrives 8 + 16*8 + SB_TICK ticks after rx_s first goes low,
    // and rx_s trails the line by two clocks.
    always @(negedge clk) begin
        if (!reset) begin
            if (done16) begin
                check("pulse16_expected", int'(q16.size() > 0), 1);
                if (q16.size() > 0) begin
                    e16 = q16.pop_front();
                    check("dout16", dout16, e16.d);
                    check("ferr16", ferr16, e16.err);
                    check("lat16", cyc - e16.t0, 2 + 8 + 16 * 8 + 16);
                end
            end else begin
                check("ferr16_nopulse", ferr16, 0);
            end
            if (done32) begin
                check("pulse32_expected", int'(q32.size() > 0), 1);
                if (q32.size() > 0) begin
                    e32 = q32.pop_front();
                    check("dout32", dout32, e32.d);
                    check("ferr32", ferr32, e32.err);
                    check("lat32", cyc - e32.t0, 2 + 8 + 16 * 8 + 32);
                end
            end else begin
                check("ferr32_nopulse", ferr32, 0);
            end
        end
    end

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx32 = v;
        else rx16 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit stop, input int gap,
                        input logic [7:0] exp_d, input bit exp_err);
        exp_t e;
        e.d = exp_d;
        e.err = exp_err;
        e.t0 = cyc;
        if (sel) q32.push_back(e);
        else q16.push_back(e);
        drive(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
        drive(sel, stop, sel ? 32 : 16);
        drive(sel, 1'b1, gap);
    endtask

    task automatic drain(input string nm);
        repeat (40) @(posedge clk);
        #1;
        check({nm, "_pending16"}, q16.size(), 0);
        check({nm, "_pending32"}, q32.size(), 0);
    endtask

    initial begin
        logic [7:0] rd;
        bit         rs;
        int         rg;
        tbl[0] = '{0, 8'hA5, 1, 16, 8'hA5, 0};
        tbl[1] = '{0, 8'h55, 0, 24, 8'h55, 1};
        tbl[2] = '{0, 8'h00, 1, 0,  8'h00, 0};
        tbl[3] = '{0, 8'hFF, 1, 5,  8'hFF, 0};
        tbl[4] = '{1, 8'h00, 1, 0,  8'h00, 0};
        tbl[5] = '{1, 8'hFF, 1, 8,  8'hFF, 0};

        repeat (3) @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_done", done16, 0);
            check("rst_ferr", ferr16, 0);
            check("rst_dout16", dout16, 0);
            check("rst_dout32", dout32, 0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            send(tbl[i].sel, tbl[i].d, tbl[i].stop, tbl[i].gap, tbl[i].exp_d, tbl[i].exp_err);
        drain("table");

        // glitch: 4 low ticks must be rejected at mid-bit
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 24);
        send(0, 8'h3C, 1, 10, 8'h3C, 0);
        drain("glitch");

        // reset in the middle of data bit 3 of 8'hFF
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16 * 3 + 8);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("abort_dout", dout16, 0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 120);
        send(0, 8'h81, 1, 10, 8'h81, 0);
        drain("abort");

        for (int i = 0; i < 30; i++) begin
            rd = 8'($urandom);
            rs = ($urandom % 5) != 0;
            rg = rs ? int'($urandom % 6) : 20 + int'($urandom % 10);
            send(0, rd, rs, rg, rd, !rs);
        end
        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom);
            rg = int'($urandom % 4);
            send(1, rd, 1, rg, rd, 0);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
